// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and pipeline-register records used by execute and memory.
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } m_rec_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } w_rec_t;

    localparam m_rec_t M_NOP = '{stat: STAT_AOK, icode: I_NOP, cnd: 1'b0,
                                 val_e: 64'd0, val_a: 64'd0, dst_e: RNONE, dst_m: RNONE};
    localparam w_rec_t W_NOP = '{stat: STAT_AOK, icode: I_NOP, val_e: 64'd0,
                                 val_m: 64'd0, dst_e: RNONE, dst_m: RNONE};

endpackage

// File: rtl/memory_pipe_if.sv
// Signal bundle between execute/control, the memory stage, and write-back.
interface memory_pipe_if;

    logic [2:0]  EE_stat;
    logic [3:0]  EE_icode;
    logic        e_cnd;
    logic [63:0] e_valE;
    logic [63:0] EE_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  EE_dstM;
    logic        M_bubble;
    logic        W_stall;

    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;

    modport master (
        output EE_stat, EE_icode, e_cnd, e_valE, EE_valA, e_dstE, EE_dstM, M_bubble, W_stall,
        input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, m_valM, m_stat,
               W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );

    modport slave (
        input  EE_stat, EE_icode, e_cnd, e_valE, EE_valA, e_dstE, EE_dstM, M_bubble, W_stall,
        output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, m_valM, m_stat,
               W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );

endinterface

// File: rtl/data_mem.sv
// Byte-addressed data memory: 8-byte little-endian access, combinational read, synchronous write.
module data_mem #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    mem_reg [MEM_BYTES];
    logic [AW-1:0] base;

    assign base = addr[AW-1:0];
    // Unsigned compare also rejects every address with bit 63 set.
    assign err  = addr > 64'(MEM_BYTES - 8);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rd
            logic [AW-1:0] idx;
            assign idx              = base + AW'(gi);
            assign rdata[8*gi +: 8] = mem_reg[idx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem_reg[base + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_pipe.sv
// Y86-64 memory stage: M pipeline register, data-memory access, W pipeline register.
import y86_pkg::*;

module memory_pipe #(
    parameter int MEM_BYTES = 1024
) (
    input logic         clk,
    input logic         reset,
    memory_pipe_if.slave bus
);

    m_rec_t      m_reg;
    w_rec_t      w_reg;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata;
    logic        addr_err;
    logic        dmem_error;
    logic [63:0] m_val_m;
    logic [2:0]  m_stat_c;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 64'd0;
        unique case (m_reg.icode)
            I_RMMOVQ, I_PUSHQ, I_CALL: begin
                mem_write = 1'b1;
                mem_addr  = m_reg.val_e;
            end
            I_MRMOVQ: begin
                mem_read = 1'b1;
                mem_addr = m_reg.val_e;
            end
            I_POPQ, I_RET: begin
                mem_read = 1'b1;
                mem_addr = m_reg.val_a;
            end
            default: ;
        endcase
    end

    assign dmem_error = (mem_read | mem_write) & addr_err;
    assign m_val_m    = (mem_read & ~dmem_error) ? mem_rdata : 64'd0;
    assign m_stat_c   = dmem_error ? STAT_ADR : m_reg.stat;

    // Reset suppresses a store still sitting in M; bubble/stall deliberately do not.
    data_mem #(.MEM_BYTES(MEM_BYTES)) u_data_mem (
        .clk   (clk),
        .we    (mem_write & ~addr_err & ~reset),
        .addr  (mem_addr),
        .wdata (m_reg.val_a),
        .rdata (mem_rdata),
        .err   (addr_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            m_reg <= M_NOP;
        end else if (bus.M_bubble) begin
            m_reg <= M_NOP;
        end else begin
            m_reg <= '{stat: bus.EE_stat, icode: bus.EE_icode, cnd: bus.e_cnd,
                       val_e: bus.e_valE, val_a: bus.EE_valA,
                       dst_e: bus.e_dstE, dst_m: bus.EE_dstM};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_reg <= W_NOP;
        end else if (!bus.W_stall) begin
            w_reg <= '{stat: m_stat_c, icode: m_reg.icode, val_e: m_reg.val_e,
                       val_m: m_val_m, dst_e: m_reg.dst_e, dst_m: m_reg.dst_m};
        end
    end

    assign bus.M_stat  = m_reg.stat;
    assign bus.M_icode = m_reg.icode;
    assign bus.M_cnd   = m_reg.cnd;
    assign bus.M_valE  = m_reg.val_e;
    assign bus.M_valA  = m_reg.val_a;
    assign bus.M_dstE  = m_reg.dst_e;
    assign bus.M_dstM  = m_reg.dst_m;
    assign bus.m_valM  = m_val_m;
    assign bus.m_stat  = m_stat_c;
    assign bus.W_stat  = w_reg.stat;
    assign bus.W_icode = w_reg.icode;
    assign bus.W_valE  = w_reg.val_e;
    assign bus.W_valM  = w_reg.val_m;
    assign bus.W_dstE  = w_reg.dst_e;
    assign bus.W_dstM  = w_reg.dst_m;

endmodule

// File: tb/tb_memory_pipe.sv
// Directed bench for memory_pipe: drives instructions into M and checks M, m and W outputs.
module tb_memory_pipe;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    memory_pipe_if bus ();

    memory_pipe #(.MEM_BYTES(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one instruction on the execute side, clock it into M, return at the next falling edge.
    task automatic issue(input logic [3:0] icode, input logic [63:0] val_e, input logic [63:0] val_a,
                         input logic [3:0] dst_e, input logic [3:0] dst_m);
        bus.EE_stat  = 3'd1;
        bus.EE_icode = icode;
        bus.e_cnd    = 1'b0;
        bus.e_valE   = val_e;
        bus.EE_valA  = val_a;
        bus.e_dstE   = dst_e;
        bus.EE_dstM  = dst_m;
        @(posedge clk);
        @(negedge clk);
        $display("txn icode=%h valE=%h valA=%h bubble=%0b stall=%0b",
                 icode, val_e, val_a, bus.M_bubble, bus.W_stall);
    endtask

    task automatic nop();
        issue(4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
    endtask

    initial begin
        reset        = 1'b1;
        bus.M_bubble = 1'b0;
        bus.W_stall  = 1'b0;
        bus.EE_stat  = 3'd1;
        bus.EE_icode = 4'h1;
        bus.e_cnd    = 1'b0;
        bus.e_valE   = 64'd0;
        bus.EE_valA  = 64'd0;
        bus.e_dstE   = 4'hF;
        bus.EE_dstM  = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);

        check_val("rst_M_stat",  bus.M_stat,  1);
        check_val("rst_M_icode", bus.M_icode, 1);
        check_val("rst_M_dstE",  bus.M_dstE,  4'hF);
        check_val("rst_M_valA",  bus.M_valA,  0);
        check_val("rst_W_stat",  bus.W_stat,  1);
        check_val("rst_W_icode", bus.W_icode, 1);
        check_val("rst_W_dstM",  bus.W_dstM,  4'hF);
        check_val("rst_W_valM",  bus.W_valM,  0);
        check_val("rst_m_stat",  bus.m_stat,  1);
        check_val("rst_m_valM",  bus.m_valM,  0);
        reset = 1'b0;

        // rmmovq then mrmovq at 0x10
        issue(4'h4, 64'h10, 64'h1122334455667788, 4'hF, 4'hF);
        check_val("rm_m_stat", bus.m_stat, 1);
        check_val("rm_m_valM", bus.m_valM, 0);
        issue(4'h5, 64'h10, 64'd0, 4'hF, 4'h3);
        check_val("mr_m_valM", bus.m_valM, 64'h1122334455667788);
        nop();
        check_val("mr_W_valM",  bus.W_valM,  64'h1122334455667788);
        check_val("mr_W_stat",  bus.W_stat,  1);
        check_val("mr_W_icode", bus.W_icode, 5);
        check_val("mr_W_dstM",  bus.W_dstM,  3);

        // pushq at the top legal address, popq reads back through valA
        issue(4'hA, 64'h3F8, 64'd7, 4'h4, 4'hF);
        check_val("push_m_stat", bus.m_stat, 1);
        issue(4'hB, 64'h400, 64'h3F8, 4'h4, 4'h0);
        check_val("pop_m_valM", bus.m_valM, 7);
        check_val("pop_M_dstM", bus.M_dstM, 0);
        nop();
        check_val("pop_W_dstM", bus.W_dstM, 0);
        check_val("pop_W_valM", bus.W_valM, 7);
        check_val("pop_W_valE", bus.W_valE, 64'h400);

        // Address errors
        issue(4'h5, 64'd1017, 64'd0, 4'hF, 4'h2);
        check_val("oob_rd_m_stat", bus.m_stat, 3);
        check_val("oob_rd_m_valM", bus.m_valM, 0);
        nop();
        check_val("oob_rd_W_stat", bus.W_stat, 3);
        check_val("oob_rd_W_valM", bus.W_valM, 0);
        issue(4'h5, 64'd1016, 64'd0, 4'hF, 4'h2);
        check_val("edge_rd_m_stat", bus.m_stat, 1);
        issue(4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD_BEEF, 4'hF, 4'hF);
        check_val("oob_wr_m_stat", bus.m_stat, 3);
        issue(4'h5, 64'h3F8, 64'd0, 4'hF, 4'h2);
        check_val("oob_wr_unchanged", bus.m_valM, 7);

        // Bubble over a call: M becomes nop, no store happens
        bus.M_bubble = 1'b1;
        issue(4'h8, 64'h3F8, 64'h99, 4'h4, 4'hF);
        bus.M_bubble = 1'b0;
        check_val("bub_M_icode", bus.M_icode, 1);
        check_val("bub_M_valE",  bus.M_valE,  0);
        issue(4'h5, 64'h3F8, 64'd0, 4'hF, 4'h2);
        check_val("bub_no_write", bus.m_valM, 7);
        nop();
        check_val("pre_stall_W_valM", bus.W_valM, 7);

        // Stall W for three cycles while M keeps moving
        bus.W_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(4'h3, 64'hAA + 64'(i), 64'd0, 4'h1, 4'hF);
            check_val("stall_W_valM",  bus.W_valM,  7);
            check_val("stall_W_dstM",  bus.W_dstM,  2);
            check_val("stall_W_icode", bus.W_icode, 5);
            check_val("stall_M_valE",  bus.M_valE,  64'hAA + 64'(i));
        end
        bus.W_stall = 1'b0;
        nop();
        check_val("unstall_W_valE",  bus.W_valE,  64'hAC);
        check_val("unstall_W_icode", bus.W_icode, 3);

        // Reset while a store sits in M
        issue(4'h4, 64'h20, 64'h5555, 4'hF, 4'hF);
        issue(4'h4, 64'h20, 64'hBAD, 4'hF, 4'hF);
        reset = 1'b1;
        nop();
        reset = 1'b0;
        check_val("rstw_M_icode", bus.M_icode, 1);
        check_val("rstw_W_icode", bus.W_icode, 1);
        check_val("rstw_W_stat",  bus.W_stat,  1);
        issue(4'h5, 64'h20, 64'd0, 4'hF, 4'h2);
        check_val("rstw_kept", bus.m_valM, 64'h5555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
